// File: rtl/iobus_initiator.sv
// Bus-exercising initiator: writes a counting pattern to NUM_TXN addresses and reads each one back,
// checking the data, with one command outstanding at a time and a per-phase timeout.
module iobus_initiator #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    NUM_TXN        = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE    = ADDR_WIDTH'(4),
  parameter logic [DATA_WIDTH-1:0] DATA_SEED      = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [15:0]           txn_count,
  output logic [2:0]            MCmd,
  output logic [ADDR_WIDTH-1:0] MAddr,
  output logic [DATA_WIDTH-1:0] MData,
  input  logic                  SCmdAccept,
  input  logic [1:0]            SResp,
  input  logic [DATA_WIDTH-1:0] SData
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_CMD  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [1:0] RESP_DVA = 2'd1;

  state_t                  state, state_nxt;
  logic [15:0]             idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [31:0]             tcnt;

  logic start_run;
  logic tmo_hit;
  logic rd_done;
  logic err_inc;
  logic tcnt_last;
  logic last_pair;
  logic [16:0] idx_p1;

  assign start_run = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign tcnt_last = (tcnt == 32'(TIMEOUT_CYCLES - 1));
  assign idx_p1    = {1'b0, idx} + 17'd1;
  assign last_pair = (idx_p1 >= 17'(NUM_TXN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WR_CMD;
      S_WR_CMD: begin
        if (SCmdAccept)     state_nxt = S_WR_RESP;
        else if (tcnt_last) begin state_nxt = S_DONE; tmo_hit = 1'b1; end
      end
      S_WR_RESP: begin
        if (SResp != 2'd0)  state_nxt = S_RD_CMD;
        else if (tcnt_last) begin state_nxt = S_DONE; tmo_hit = 1'b1; end
      end
      S_RD_CMD: begin
        if (SCmdAccept)     state_nxt = S_RD_RESP;
        else if (tcnt_last) begin state_nxt = S_DONE; tmo_hit = 1'b1; end
      end
      S_RD_RESP: begin
        if (SResp != 2'd0) begin
          rd_done   = 1'b1;
          state_nxt = last_pair ? S_DONE : S_WR_CMD;
        end else if (tcnt_last) begin
          state_nxt = S_DONE;
          tmo_hit   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Responses only matter in the response phases; SResp=2 is treated like ERR.
  always_comb begin
    err_inc = tmo_hit;
    if (state == S_WR_RESP && SResp[1])
      err_inc = 1'b1;
    if (state == S_RD_RESP && (SResp[1] || (SResp == RESP_DVA && SData != data_q)))
      err_inc = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      err_count <= '0;
      txn_count <= '0;
      timeout   <= 1'b0;
    end else if (start_run) begin
      idx       <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= DATA_SEED;
      err_count <= '0;
      txn_count <= '0;
      timeout   <= 1'b0;
    end else begin
      if (err_inc && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (tmo_hit)
        timeout <= 1'b1;
      if (rd_done) begin
        txn_count <= txn_count + 16'd1;
        idx       <= idx + 16'd1;
        addr_q    <= addr_q + ADDR_STRIDE;
        data_q    <= data_q + DATA_WIDTH'(1);
      end
    end
  end

  // Phase timer restarts on every state change, including re-entry of WR_CMD from DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   tcnt <= '0;
    else if (state_nxt != state) tcnt <= '0;
    else if (busy)               tcnt <= tcnt + 32'd1;
  end

  always_comb begin
    MCmd  = CMD_IDLE;
    MAddr = '0;
    MData = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_WR_CMD: begin
        MCmd  = CMD_WR;
        MAddr = addr_q;
        MData = data_q;
        busy  = 1'b1;
      end
      S_RD_CMD: begin
        MCmd  = CMD_RD;
        MAddr = addr_q;
        busy  = 1'b1;
      end
      S_WR_RESP, S_RD_RESP: busy = 1'b1;
      S_DONE:               done = 1'b1;
      default: ;
    endcase
  end

  assign pass = done && (err_count == 16'd0) && !timeout;

endmodule

// File: tb/tb_iobus_initiator.sv
// Directed bench for iobus_initiator: behavioural slave with configurable accept latency and
// response modes, a vector table of whole runs, and a hand-written reset-mid-run sequence.
module tb_iobus_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, txn_count;
  logic [2:0]  MCmd;
  logic [31:0] MAddr, MData;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [31:0] SData;

  always #5 clk = ~clk;

  iobus_initiator #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_TXN(4), .BASE_ADDR(32'h0),
    .ADDR_STRIDE(32'h4), .DATA_SEED(32'h0), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .txn_count(txn_count),
    .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
    .SCmdAccept(SCmdAccept), .SResp(SResp), .SData(SData)
  );

  // Slave model: mode 0 memory, 1 static 32'h1 read data, 2 ERR on the write to address 8.
  int          acc_lat;
  bit          acc_en;
  int          mode;
  logic [1:0]  stray_resp;
  int          wait_cnt;
  logic        pend;
  logic        pend_err;
  logic [3:0]  pend_idx;
  logic [31:0] mem [16];

  assign SCmdAccept = acc_en && (MCmd != 3'd0) && (wait_cnt == acc_lat);
  assign SResp      = pend ? (pend_err ? 2'd3 : 2'd1) : stray_resp;
  assign SData      = (mode == 1) ? 32'h1 : mem[pend_idx];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
      pend     <= 1'b0;
      pend_err <= 1'b0;
      pend_idx <= '0;
    end else begin
      if (MCmd != 3'd0 && !SCmdAccept) wait_cnt <= wait_cnt + 1;
      else                             wait_cnt <= 0;
      if (SCmdAccept) begin
        pend     <= 1'b1;
        pend_idx <= MAddr[5:2];
        pend_err <= (mode == 2) && (MCmd == 3'd1) && (MAddr == 32'h8);
        if (MCmd == 3'd1) mem[MAddr[5:2]] <= MData;
      end else if (pend) begin
        pend <= 1'b0;
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    lat;
    bit    en;
    int    md;
    int    exp_busy;
    int    exp_cmdcyc;
    int    exp_err;
    int    exp_txn;
    bit    exp_pass;
    bit    exp_tmo;
  } vec_t;

  // One complete run from IDLE/DONE; checks every command cycle against the expected command.
  task automatic run_vec(input vec_t v);
    int busy_cyc, cmd_cyc, ncmd, bad;
    logic [2:0]  e_cmd;
    logic [31:0] e_addr, e_data;
    bit finished;
    busy_cyc = 0; cmd_cyc = 0; ncmd = 0; bad = 0; finished = 0;
    acc_lat = v.lat; acc_en = v.en; mode = v.md;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!busy) begin finished = 1; break; end
      busy_cyc++;
      start = (busy_cyc == 5);
      if (MCmd != 3'd0) begin
        cmd_cyc++;
        e_cmd  = (ncmd % 2 == 0) ? 3'd1 : 3'd2;
        e_addr = 32'((ncmd / 2) * 4);
        e_data = (ncmd % 2 == 0) ? 32'(ncmd / 2) : 32'h0;
        if (MCmd !== e_cmd || MAddr !== e_addr || MData !== e_data) begin
          if (bad == 0)
            $display("%s: cmd %0d cyc %0d got cmd=%0d addr=%0h data=%0h", v.name, ncmd, busy_cyc, MCmd, MAddr, MData);
          bad++;
        end
        if (SCmdAccept) ncmd++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({v.name, " finished"}, 64'(finished), 64'd1);
    chk({v.name, " cmd_bad_cycles"}, 64'(bad), 64'd0);
    chk({v.name, " busy_cycles"}, 64'(busy_cyc), 64'(v.exp_busy));
    chk({v.name, " cmd_cycles"}, 64'(cmd_cyc), 64'(v.exp_cmdcyc));
    chk({v.name, " err_count"}, 64'(err_count), 64'(v.exp_err));
    chk({v.name, " txn_count"}, 64'(txn_count), 64'(v.exp_txn));
    chk({v.name, " pass"}, 64'(pass), 64'(v.exp_pass));
    chk({v.name, " timeout"}, 64'(timeout), 64'(v.exp_tmo));
    repeat (3) @(negedge clk);
    chk({v.name, " done_sticky"}, 64'(done), 64'd1);
    chk({v.name, " mcmd_idle"}, 64'(MCmd), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " outputs"},
        {busy, done, pass, timeout, err_count, txn_count, MCmd, 21'd0},
        64'd0);
    chk({name, " maddr_mdata"}, {MAddr, MData}, 64'd0);
  endtask

  vec_t vecs [5];

  initial begin
    vec_t ref_run;
    bit   hit;
    vecs[0] = '{"mem_lat0",   0, 1'b1, 0, 16,  8, 0, 4, 1'b1, 1'b0};
    vecs[1] = '{"static1",    0, 1'b1, 1, 16,  8, 3, 4, 1'b0, 1'b0};
    vecs[2] = '{"no_accept",  0, 1'b0, 0,  8,  8, 1, 0, 1'b0, 1'b1};
    vecs[3] = '{"wr_err_i2",  0, 1'b1, 2, 16,  8, 1, 4, 1'b0, 1'b0};
    vecs[4] = '{"mem_lat3",   3, 1'b1, 0, 40, 32, 0, 4, 1'b1, 1'b0};
    ref_run = vecs[0];

    reset = 1'b1; start = 1'b0; stray_resp = 2'd0;
    acc_lat = 0; acc_en = 1'b1; mode = 0;
    for (int k = 0; k < 16; k++) mem[k] = 32'hDEAD_0000 + 32'(k);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Reset during RD_RESP of pair 1: wait for the read of address 4 to be accepted.
    acc_lat = 0; acc_en = 1'b1; mode = 0;
    hit = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (MCmd == 3'd2 && SCmdAccept && MAddr == 32'h4) begin hit = 1; break; end
      @(negedge clk);
    end
    chk("rst_mid reached_rd_i1", 64'(hit), 64'd1);
    @(posedge clk);
    #2;
    chk("rst_mid busy_before", 64'(busy), 64'd1);
    chk("rst_mid sresp_pending", 64'(SResp), 64'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk) reset = 1'b0;
    stray_resp = 2'd1;
    repeat (3) @(negedge clk);
    stray_resp = 2'd3;
    repeat (2) @(negedge clk);
    chk_all_zero("stray_resp");
    stray_resp = 2'd0;
    @(negedge clk);
    ref_run.name = "after_reset";
    run_vec(ref_run);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iobus_initiator.md
IOBUS_INITIATOR -- requirements
Module: iobus_initiator

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data bus width; ADDR_WIDTH, 32, address width; NUM_TXN, 16, write/read-back pairs per run (1..65535); BASE_ADDR, 0, first address; ADDR_STRIDE, 4, address increment; DATA_SEED, 0, pattern seed; TIMEOUT_CYCLES, 256, per-phase timeout (>=1).
REQ-002 Ports SHALL be: clk in 1 clock; reset in 1 asynchronous active-high reset.
REQ-003 start in 1 pulse to begin a run; busy out 1 run in progress; done out 1 run finished (sticky); pass out 1 done with no errors and no timeout; timeout out 1 run aborted on timeout; err_count out 16 saturating error count; txn_count out 16 completed read-backs.
REQ-004 MCmd out 3 command (0 IDLE, 1 WR, 2 RD); MAddr out ADDR_WIDTH address; MData out DATA_WIDTH write data; SCmdAccept in 1 slave accepts command; SResp in 2 response (0 NULL, 1 DVA, 3 ERR); SData in DATA_WIDTH read data.

Function
REQ-005 FSM states SHALL be IDLE, WR_CMD, WR_RESP, RD_CMD, RD_RESP, DONE; index i (16 bit) selects the pair.
REQ-006 IDLE or DONE + start=1 -> WR_CMD with i=0, err_count=0, txn_count=0, timeout=0, done=0; start while busy SHALL be ignored.
REQ-007 addr(i) = BASE_ADDR + i*ADDR_STRIDE mod 2^ADDR_WIDTH; data(i) = DATA_SEED + i mod 2^DATA_WIDTH.
REQ-008 WR_CMD: MCmd=1, MAddr=addr(i), MData=data(i), all held stable until SCmdAccept=1 at a rising edge -> WR_RESP.
REQ-009 RD_CMD: MCmd=2, MAddr=addr(i), MData=0, held until accepted -> RD_RESP.
REQ-010 In WR_RESP/RD_RESP, MCmd SHALL be 0; responses SHALL arrive >=1 cycle after acceptance; SResp=NULL waits.
REQ-011 WR_RESP + SResp!=NULL -> RD_CMD; SResp=ERR (or 2) increments err_count.
REQ-012 RD_RESP + SResp=DVA: SData!=data(i) increments err_count; SResp=ERR (or 2) increments err_count without compare; either way txn_count++, i++; then RD_RESP -> WR_CMD if i+1<NUM_TXN else DONE.
REQ-013 SResp values outside *_RESP states SHALL be ignored.
REQ-014 Timeout counter SHALL clear on every state entry and increment each cycle in *_CMD/*_RESP; reaching TIMEOUT_CYCLES without leaving the state -> timeout=1, err_count++, MCmd=0 next cycle, DONE.
REQ-015 err_count SHALL saturate at 16'hFFFF; simultaneous error sources in one cycle count once.
REQ-016 busy=1 in all states except IDLE and DONE; done=1 only in DONE; pass = done & (err_count==0) & ~timeout.
REQ-017 Throughput: exactly one outstanding command; zero-latency accept and 1-cycle response SHALL yield 4 cycles per pair.

Reset
REQ-018 reset=1 SHALL immediately (asynchronously) force state IDLE, MCmd=0, MAddr=0, MData=0, busy=0, done=0, pass=0, timeout=0, err_count=0, txn_count=0, i=0, timeout counter=0.
REQ-019 Reset mid-run SHALL abandon any outstanding transaction; the next start begins at i=0.

Verification
REQ-020 NUM_TXN=4, memory slave, accept latency 0, return latency 1 -> MCmd sequence WR/RD at 0,0,4,4,8,8,12,12; done after 16 cycles; err_count=0, txn_count=4, pass=1.
REQ-021 NUM_TXN=4, slave returning static 32'h1 -> err_count=3 (only i=1 matches), pass=0, timeout=0.
REQ-022 SCmdAccept tied 0, TIMEOUT_CYCLES=8 -> MCmd=1, MAddr=BASE_ADDR stable 8 cycles, then MCmd=0, timeout=1, err_count=1, done=1.
REQ-023 SResp=ERR on write response of i=2, NUM_TXN=4 -> run completes, err_count=1, txn_count=4.
REQ-024 Accept latency 3 -> MCmd/MAddr/MData stable 4 cycles per command; results as REQ-020.
REQ-025 reset pulsed during RD_RESP of i=1 -> all outputs 0 same cycle; stray SResp afterwards ignored; new start reproduces REQ-020.
